// File: rtl/refill_seq_pkg.sv
// refill_seq_pkg: shared widths, beat-address packing and sequencer states
package refill_seq_pkg;
   localparam int WAY_W_DEF  = 3;
   localparam int SET_W_DEF  = 10;
   localparam int BEAT_W_DEF = 3;
   typedef struct packed {
      logic                  mask;
      logic [BEAT_W_DEF-1:0] beat;
      logic [SET_W_DEF-1:0]  set;
      logic [WAY_W_DEF-1:0]  way;
      logic                  noop;
   } beat_addr_t;
   typedef enum logic {IDLE, ISSUE} seq_state_e;
endpackage

// File: rtl/refill_beat_sequencer.sv
// refill_beat_sequencer: expands one refill request into in-order per-beat bank addresses
// Ports: req_* request handshake and fields; out_* beat address to the bank-address queue;
// done pulses on the final-beat handshake. Define REFILL_SEQ_NOOP_COLLAPSE_EN to issue
// noop requests as a single beat.
module refill_beat_sequencer
   import refill_seq_pkg::*;
#(
   parameter int WAY_W  = WAY_W_DEF,
   parameter int SET_W  = SET_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_noop,
   input  logic [WAY_W-1:0]  req_way,
   input  logic [SET_W-1:0]  req_set,
   input  logic [BEAT_W-1:0] req_last_beat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_noop,
   output logic [WAY_W-1:0]  out_way,
   output logic [SET_W-1:0]  out_set,
   output logic [BEAT_W-1:0] out_beat,
   output logic              out_mask,
   output logic              out_last,
   output logic              done
);
   seq_state_e        state, state_nxt;
   logic              noop, noop_nxt;
   logic [WAY_W-1:0]  way, way_nxt;
   logic [SET_W-1:0]  set, set_nxt;
   logic [BEAT_W-1:0] last, last_nxt;
   logic [BEAT_W-1:0] cnt, cnt_nxt;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         noop  <= 1'b0;
         way   <= '0;
         set   <= '0;
         last  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         noop  <= noop_nxt;
         way   <= way_nxt;
         set   <= set_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      noop_nxt  = noop;
      way_nxt   = way;
      set_nxt   = set;
      last_nxt  = last;
      cnt_nxt   = cnt;
      out_valid = state == ISSUE;
      out_last  = out_valid && cnt == last;
      out_beat  = out_valid ? cnt : '0;
      out_mask  = out_valid;
      out_noop  = noop;
      out_way   = way;
      out_set   = set;
      done      = out_valid && out_ready && out_last;
      req_ready = !out_valid || (out_ready && out_last);
      if (out_valid && out_ready && !out_last) cnt_nxt = cnt + 1'b1;
      if (done) state_nxt = IDLE;
      // a request accepted on the final-beat handshake overrides the return to IDLE
      if (req_valid && req_ready) begin
         state_nxt = ISSUE;
         noop_nxt  = req_noop;
         way_nxt   = req_way;
         set_nxt   = req_set;
         cnt_nxt   = '0;
`ifdef REFILL_SEQ_NOOP_COLLAPSE_EN
         last_nxt  = req_noop ? '0 : req_last_beat;
`else
         last_nxt  = req_last_beat;
`endif
      end
   end
endmodule

// File: tb/tb_refill_beat_sequencer.sv
// tb_refill_beat_sequencer: table vectors, corner sequences and a random run against a beat-queue model
module tb_refill_beat_sequencer;
   import refill_seq_pkg::*;
   logic       clock = 1'b0, reset = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_noop = 1'b0;
   logic [2:0] req_way = '0, req_last_beat = '0;
   logic [9:0] req_set = '0;
   logic       out_valid, out_ready = 1'b1, out_noop, out_mask, out_last, done;
   logic [2:0] out_way, out_beat;
   logic [9:0] out_set;
   int checks = 0, errors = 0;

   refill_beat_sequencer dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_noop(req_noop),
      .req_way(req_way), .req_set(req_set), .req_last_beat(req_last_beat),
      .out_valid(out_valid), .out_ready(out_ready), .out_noop(out_noop),
      .out_way(out_way), .out_set(out_set), .out_beat(out_beat),
      .out_mask(out_mask), .out_last(out_last), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rv;
      logic [2:0] way;
      logic [9:0] set;
      logic [2:0] lb;
      logic       rr, ov;
      logic [2:0] beat;
      logic       last, dn;
      logic [2:0] ew;
   } vec_t;
   vec_t tbl[15];

   typedef struct {
      bit       noop;
      bit [2:0] way;
      bit [9:0] set;
      bit [2:0] beat;
      bit       last;
   } beat_t;
   beat_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic np, input logic [2:0] w, input logic [9:0] s,
                        input logic [2:0] lb, input logic ordy);
      req_valid = rv; req_noop = np; req_way = w; req_set = s; req_last_beat = lb; out_ready = ordy;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      drive(1'b1, 1'b0, 3'd1, 10'd1, 3'd1, 1'b1);
      tick; tick;
      reset = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 10'd0, 3'd0, 1'b1);
   endtask

   initial begin
      int n;
      tbl[0] = '{1'b1, 3'd5, 10'h2A3, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
      for (int k = 1; k <= 8; k++)
         tbl[k] = '{1'b0, 3'd0, 10'd0, 3'd0, k == 8, 1'b1, 3'(k - 1), k == 8, k == 8, 3'd5};
      tbl[9]  = '{1'b1, 3'd1, 10'd3, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
      tbl[10] = '{1'b1, 3'd2, 10'd7, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd1};
      tbl[11] = '{1'b1, 3'd2, 10'd7, 3'd0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd1};
      tbl[12] = '{1'b1, 3'd6, 10'd1, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd2};
      tbl[13] = '{1'b0, 3'd0, 10'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd6};
      tbl[14] = '{1'b0, 3'd0, 10'd0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};

      do_reset;
      @(negedge clock);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      tick;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rv, 1'b0, tbl[i].way, tbl[i].set, tbl[i].lb, 1'b1);
         @(negedge clock);
         chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].rr);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("tbl%0d_out_beat", i), out_beat, tbl[i].beat);
         chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].last);
         chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
         chk($sformatf("tbl%0d_out_mask", i), out_mask, tbl[i].ov);
         if (tbl[i].ov) chk($sformatf("tbl%0d_out_way", i), out_way, tbl[i].ew);
         tick;
      end

      drive(1'b1, 1'b0, 3'd3, 10'h055, 3'd7, 1'b1);
      tick;
      for (int i = 0; i < 11; i++) begin
         int eb;
         eb = i < 2 ? i : (i < 6 ? 2 : i - 3);
         drive(1'b0, 1'b0, 3'd0, 10'd0, 3'd0, !(i >= 2 && i < 5));
         @(negedge clock);
         chk($sformatf("stall%0d_valid", i), out_valid, 1);
         chk($sformatf("stall%0d_beat", i), out_beat, eb);
         chk($sformatf("stall%0d_set", i), out_set, 10'h055);
         chk($sformatf("stall%0d_done", i), done, eb == 7 && out_ready);
         tick;
      end
      @(negedge clock);
      chk("stall_end_valid", out_valid, 0);
      tick;

      drive(1'b1, 1'b1, 3'd4, 10'h100, 3'd3, 1'b1);
      tick;
      drive(1'b0, 1'b0, 3'd0, 10'd0, 3'd0, 1'b1);
`ifdef REFILL_SEQ_NOOP_COLLAPSE_EN
      n = 1;
`else
      n = 4;
`endif
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk($sformatf("noop%0d_valid", i), out_valid, 1);
         chk($sformatf("noop%0d_beat", i), out_beat, i);
         chk($sformatf("noop%0d_noop", i), out_noop, 1);
         chk($sformatf("noop%0d_last", i), out_last, i == n - 1);
         tick;
      end
      @(negedge clock);
      chk("noop_end_valid", out_valid, 0);
      tick;

      drive(1'b1, 1'b0, 3'd4, 10'h0F0, 3'd7, 1'b1);
      tick;
      drive(1'b0, 1'b0, 3'd0, 10'd0, 3'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk($sformatf("rstmid%0d_beat", i), out_beat, i);
         tick;
      end
      reset = 1'b1;
      @(negedge clock);
      chk("rstmid_beat4", out_beat, 4);
      chk("rstmid_done", done, 0);
      tick;
      reset = 1'b0;
      @(negedge clock);
      chk("rstmid_after_valid", out_valid, 0);
      chk("rstmid_after_ready", req_ready, 1);
      chk("rstmid_after_done", done, 0);
      drive(1'b1, 1'b0, 3'd7, 10'h3FF, 3'd1, 1'b1);
      tick;
      drive(1'b0, 1'b0, 3'd0, 10'd0, 3'd0, 1'b1);
      @(negedge clock);
      chk("restart_beat0", out_beat, 0);
      chk("restart_valid", out_valid, 1);
      chk("restart_way", out_way, 7);
      tick;
      tick;

      do_reset;
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic       rr_exp;
         logic [2:0] lb;
         reset = $urandom_range(0, 199) == 0;
         lb = 3'($urandom_range(0, 7));
         drive($urandom_range(0, 1), $urandom_range(0, 3) == 0, 3'($urandom), 10'($urandom), lb,
               $urandom_range(0, 3) != 0);
         @(negedge clock);
         rr_exp = q.size() == 0 || (out_ready && q[0].last);
         chk("rnd_out_valid", out_valid, q.size() > 0);
         chk("rnd_req_ready", req_ready, rr_exp);
         chk("rnd_done", done, q.size() > 0 && out_ready && q[0].last);
         chk("rnd_out_mask", out_mask, q.size() > 0);
         if (q.size() > 0) begin
            chk("rnd_out_beat", out_beat, q[0].beat);
            chk("rnd_out_last", out_last, q[0].last);
            chk("rnd_out_noop", out_noop, q[0].noop);
            chk("rnd_out_way", out_way, q[0].way);
            chk("rnd_out_set", out_set, q[0].set);
         end else begin
            chk("rnd_idle_beat", out_beat, 0);
            chk("rnd_idle_last", out_last, 0);
         end
         if (reset) q.delete();
         else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (req_valid && rr_exp) begin
`ifdef REFILL_SEQ_NOOP_COLLAPSE_EN
               n = req_noop ? 1 : int'(lb) + 1;
`else
               n = int'(lb) + 1;
`endif
               for (int b = 0; b < n; b++)
                  q.push_back('{req_noop, req_way, req_set, 3'(b), b == n - 1});
            end
         end
         tick;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/refill_beat_sequencer.md
# refill_beat_sequencer

Expands one refill/grant request (`noop`, `way`, `set`, last beat index) into a stream of per-beat banked-store addresses `{mask, beat, set, way, noop}`. It sits directly upstream of the single-entry bank-address queue, whose enqueue port is driven by this block's `out_*` port. Issue is strictly in order at up to one beat per cycle, with zero-bubble hand-over between consecutive requests.

## Interface
- `WAY_W`, 3, way index width
- `SET_W`, 10, set index width
- `BEAT_W`, 3, beat index width; up to 2^BEAT_W beats per request

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request offered
- `req_ready`  out  1  request accepted when high with `req_valid`
- `req_noop`  in  1  request carries no data write
- `req_way`  in  WAY_W  target way
- `req_set`  in  SET_W  target set
- `req_last_beat`  in  BEAT_W  index of final beat (beats = value+1)
- `out_valid`  out  1  beat address valid
- `out_ready`  in  1  downstream queue enqueue ready
- `out_noop`  out  1  latched `req_noop`
- `out_way`  out  WAY_W  latched way
- `out_set`  out  SET_W  latched set
- `out_beat`  out  BEAT_W  current beat index
- `out_mask`  out  1  constant 1 while valid (full-beat write)
- `out_last`  out  1  current beat is final beat of request
- `done`  out  1  one-cycle pulse, combinational, on final-beat handshake

## Operation
- FSM states: IDLE, ISSUE. Registers: `noop`, `way`, `set`, `last`, `cnt`.
- Request fire = `req_valid & req_ready`. Output fire = `out_valid & out_ready`.
- IDLE: `req_ready`=1 and `out_valid`=0. On request fire, latch fields, set `cnt`=0, go to ISSUE.
- ISSUE: `out_valid`=1. Outputs: `out_beat`=`cnt`, `out_last`=(`cnt`==`last`), `out_mask`=1.
- Output fire with `out_last`=0: `cnt`+1.
- Output fire with `out_last`=1: `done`=1. If `req_valid` is also high, the new request is latched in the same cycle, `cnt`=0, and the block stays in ISSUE (no bubble). Otherwise the block goes to IDLE.
- `req_ready` = IDLE | (ISSUE & `out_ready` & `out_last`).
- Stall: while `out_valid` & !`out_ready`, all `out_*` hold stable.
- `cnt` never exceeds `last`, so it never wraps. `req_last_beat` = 2^BEAT_W-1 issues 2^BEAT_W beats.
- Outputs when not valid: `out_beat`, `out_last` and `done` are 0. Other `out_*` fields hold their last latched values and are don't-care.

## Timing
- Reset values: state IDLE, `cnt`=0, all latched fields 0. Resulting outputs: `req_ready`=1, `out_valid`=0, `out_last`=0, `done`=0.
- Latency: request fire in cycle N gives first beat valid in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready`=1. A request of B beats occupies exactly B cycles of ISSUE when unstalled.
- Reset asserted mid-request: the request is abandoned with no `done` pulse, and the block is IDLE in the cycle after reset.
- A request offered in the same cycle as reset is ignored.

## Configuration
- `REFILL_SEQ_NOOP_COLLAPSE_EN`
  - Defined: a request with `req_noop`=1 latches `last`=0, so it issues exactly one beat (beat 0, `out_last`=1, `out_noop`=1) regardless of `req_last_beat`.
  - Undefined: noop requests issue the full `req_last_beat`+1 beats, each with `out_noop`=1.

## Structure
- Shared package `refill_seq_pkg`:
  - `beat_addr_t` packed struct, MSB→LSB `{mask, beat, set, way, noop}` (18 bits at defaults), matching the downstream queue packing.
  - `seq_state_e` enum {IDLE, ISSUE}.
  - Default width constants.
- No sub-module. The downstream queue is instantiated by the parent.

## Test plan
- Reset release, then req {noop=0, way=5, set=0x2A3, last_beat=7} with `out_ready`=1 → beats 0..7 on cycles 1..8, `out_last` only on beat 7, `done` pulse on cycle 8, `req_ready`=0 during cycles 1..7.
- Same request with `out_ready` low for 3 cycles at beat 2 → beat 2 held stable for 4 cycles, beat sequence unchanged, no duplicate or skipped beat.
- Two back-to-back requests (last_beat=1, then way=2 set=7 last_beat=0) with `req_valid` held high → beats A0, A1, B0 in three consecutive cycles, `done` in cycles 2 and 3.
- Noop req last_beat=3: with `REFILL_SEQ_NOOP_COLLAPSE_EN` → single beat 0 with `out_last`=1; without it → 4 beats, all with `out_noop`=1.
- Reset asserted at beat 4 of an 8-beat request → no `done`, `out_valid`=0 and `req_ready`=1 the next cycle, and a new request then starts at beat 0.
- last_beat=0, non-noop → one beat with `out_mask`=1, `out_last`=1 and `done`=1 in the same cycle.
